data_memory_responder: RTL

Responder side of the core's data-memory interface: accepts `data_mem_addr` / `data_mem_wdata` / `data_mem_we` from the memory-access stage and returns `data_mem_out`. It contains:
- a byte-addressable synchronous RAM with size-coded writes and misalignment detection;
- a small memory-mapped I/O window holding a 64-bit cycle counter, a `tohost` register and a status register.

It sits outside `top_core`, beside the instruction memory, and is the simulation and FPGA data store.

---
 rtl/data_memory_responder_if.sv | 26 ++
 rtl/data_memory_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder_if.sv
// Data-memory bus between the core's memory-access stage and the responder.
interface data_memory_responder_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned AWIDTH = 14
);
  logic [AWIDTH-1:0] data_mem_addr;
  logic [XLEN-1:0]   data_mem_wdata;
  logic [2:0]        data_mem_we;
  logic [XLEN-1:0]   data_mem_out;

  // Core side drives address/data/size, receives read data.
  modport master (
    output data_mem_addr,
    output data_mem_wdata,
    output data_mem_we,
    input  data_mem_out
  );

  // Responder side.
  modport slave (
    input  data_mem_addr,
    input  data_mem_wdata,
    input  data_mem_we,
    output data_mem_out
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: byte-addressable word RAM with size-coded writes and
// misalignment detection, plus an MMIO window (cycle counter, tohost, status)
// occupying the top 16 bytes of the address space.
module data_memory_responder #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned AWIDTH    = 14,
  parameter              INIT_FILE = ""
) (
  input  logic                   clk,
  input  logic                   rst,
  data_memory_responder_if.slave bus,
  output logic [XLEN-1:0]        tohost,
  output logic                   tohost_valid,
  output logic                   err_misaligned
);

  localparam int unsigned WIDX  = AWIDTH - 2;
  localparam int unsigned DEPTH = 2 ** WIDX;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_BYTE = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_WORD = 3'b100;

  localparam logic [1:0] OFF_CYC_LO = 2'd0;
  localparam logic [1:0] OFF_CYC_HI = 2'd1;
  localparam logic [1:0] OFF_TOHOST = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // Storage and registered state.
  logic [XLEN-1:0] ram_q [DEPTH];
  logic [XLEN-1:0] data_out_q, data_out_d;
  logic [XLEN-1:0] tohost_q, tohost_d;
  logic            tohost_valid_q, tohost_valid_d;
  logic            err_q, err_d;
  logic [63:0]     cycle_q;
  logic [31:0]     hi_shadow_q, hi_shadow_d;

  // Decoded access.
  logic [AWIDTH-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [2:0]        we;
  logic [WIDX-1:0]   widx;
  logic [1:0]        reg_off;
  logic              is_mmio;
  logic              we_legal;
  logic              we_aligned;
  logic              wr_ok;
  logic [3:0]        lane_be;
  logic [3:0]        ram_be;
  logic [XLEN-1:0]   ram_wdata;
  logic [XLEN-1:0]   mmio_rdata;

  assign addr  = bus.data_mem_addr;
  assign wdata = bus.data_mem_wdata;
  assign we    = bus.data_mem_we;

  // Address decode, size legality/alignment and byte-lane replication.
  always_comb begin
    is_mmio    = &addr[AWIDTH-1:4];
    widx       = addr[AWIDTH-1:2];
    reg_off    = addr[3:2];
    we_legal   = 1'b1;
    we_aligned = 1'b1;
    lane_be    = 4'b0000;
    ram_wdata  = wdata;
    case (we)
      WE_NONE: ;
      WE_BYTE: begin
        lane_be   = 4'b0001 << addr[1:0];
        ram_wdata = {4{wdata[7:0]}};
      end
      WE_HALF: begin
        we_aligned = ~addr[0];
        lane_be    = addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata  = {2{wdata[15:0]}};
      end
      WE_WORD: begin
        we_aligned = (addr[1:0] == 2'b00);
        lane_be    = 4'b1111;
      end
      default: we_legal = 1'b0;
    endcase
    wr_ok  = we_legal && we_aligned && (we != WE_NONE);
    ram_be = (wr_ok && !is_mmio) ? lane_be : 4'b0000;
  end

  // MMIO read mux.
  always_comb begin
    case (reg_off)
      OFF_CYC_LO: mmio_rdata = cycle_q[31:0];
      OFF_CYC_HI: mmio_rdata = hi_shadow_q;
      OFF_TOHOST: mmio_rdata = tohost_q;
      default:    mmio_rdata = XLEN'(err_q);
    endcase
  end

  // Next-state for read data and MMIO registers.
  always_comb begin
    data_out_d     = is_mmio ? mmio_rdata : ram_q[widx];
    tohost_d       = tohost_q;
    tohost_valid_d = 1'b0;
    err_d          = err_q;
    hi_shadow_d    = hi_shadow_q;

    if ((we != WE_NONE) && (!we_legal || !we_aligned)) begin
      err_d = 1'b1;
    end

    if (is_mmio) begin
      // Reading the low half latches the matching high half.
      if (reg_off == OFF_CYC_LO) begin
        hi_shadow_d = cycle_q[63:32];
      end
      // tohost accepts only word writes; narrower ones are flagged.
      if ((reg_off == OFF_TOHOST) && wr_ok && (we != WE_WORD)) begin
        err_d = 1'b1;
      end
      if (wr_ok && (we == WE_WORD)) begin
        case (reg_off)
          OFF_TOHOST: begin
            tohost_d       = wdata;
            tohost_valid_d = 1'b1;
          end
          OFF_STATUS: err_d = 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Registered outputs, counter and shadow; asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q     <= '0;
      tohost_q       <= '0;
      tohost_valid_q <= 1'b0;
      err_q          <= 1'b0;
      cycle_q        <= '0;
      hi_shadow_q    <= '0;
    end else begin
      data_out_q     <= data_out_d;
      tohost_q       <= tohost_d;
      tohost_valid_q <= tohost_valid_d;
      err_q          <= err_d;
      cycle_q        <= cycle_q + 64'd1;
      hi_shadow_q    <= hi_shadow_d;
    end
  end

  // RAM byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_be[0]) ram_q[widx][7:0]   <= ram_wdata[7:0];
    if (ram_be[1]) ram_q[widx][15:8]  <= ram_wdata[15:8];
    if (ram_be[2]) ram_q[widx][23:16] <= ram_wdata[23:16];
    if (ram_be[3]) ram_q[widx][31:24] <= ram_wdata[31:24];
  end

  assign bus.data_mem_out = data_out_q;
  assign tohost           = tohost_q;
  assign tohost_valid     = tohost_valid_q;
  assign err_misaligned   = err_q;

endmodule
